// File: rtl/vx_dot8_pipe_if.sv
// vx_dot8_pipe_if: request/result handshake bundle for the DOT8 pipeline
interface vx_dot8_pipe_if #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 64
);
  logic                      valid_in;
  logic                      ready_in;
  logic                      is_signed_in;
  logic [NUM_LANES-1:0]      tmask_in;
  logic [NUM_LANES*XLEN-1:0] rs1_data_in;
  logic [NUM_LANES*XLEN-1:0] rs2_data_in;
  logic [TAG_WIDTH-1:0]      tag_in;
  logic                      valid_out;
  logic                      ready_out;
  logic [NUM_LANES-1:0]      tmask_out;
  logic [NUM_LANES*XLEN-1:0] data_out;
  logic [TAG_WIDTH-1:0]      tag_out;
  modport slave (
    input  valid_in, is_signed_in, tmask_in, rs1_data_in, rs2_data_in, tag_in, ready_out,
    output ready_in, valid_out, tmask_out, data_out, tag_out
  );
  modport master (
    output valid_in, is_signed_in, tmask_in, rs1_data_in, rs2_data_in, tag_in, ready_out,
    input  ready_in, valid_out, tmask_out, data_out, tag_out
  );
endinterface

// File: rtl/vx_dot8_pipe.sv
// vx_dot8_pipe: 3-stage elastic per-lane packed 8-bit dot-product pipeline
module vx_dot8_pipe #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_dot8_pipe_if.slave        dot_if,
  output logic                 busy,
  output logic [31:0]          op_count
);
  logic                             s1_v_q, s2_v_q, s3_v_q;
  logic [NUM_LANES-1:0][3:0][16:0]  s1_prod_q, s1_prod_d;
  logic [NUM_LANES-1:0][18:0]       s2_sum_q, s2_sum_d;
  logic [NUM_LANES-1:0][XLEN-1:0]   s3_data_q, s3_data_d;
  logic [NUM_LANES-1:0]             s1_mask_q, s2_mask_q, s3_mask_q;
  logic [TAG_WIDTH-1:0]             s1_tag_q, s2_tag_q, s3_tag_q;
  logic [31:0]                      op_count_q;
  logic                             s3_acc, s2_adv, s1_adv;

  // 9-bit extension makes signed and unsigned bytes share one signed multiply
  function automatic logic [16:0] mul8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] x, y;
    x = {sgn & a[7], a};
    y = {sgn & b[7], b};
    return 17'(x) * 17'(y);
  endfunction

  assign s3_acc = ~s3_v_q | dot_if.ready_out;
  assign s2_adv = ~s2_v_q | s3_acc;
  assign s1_adv = ~s1_v_q | s2_adv;

  assign dot_if.ready_in  = s1_adv;
  assign dot_if.valid_out = s3_v_q;
  assign dot_if.data_out  = s3_data_q;
  assign dot_if.tmask_out = s3_mask_q;
  assign dot_if.tag_out   = s3_tag_q;
  assign busy             = s1_v_q | s2_v_q | s3_v_q;
  assign op_count         = op_count_q;

  always_comb begin
    s1_prod_d = '0;
    s2_sum_d  = '0;
    s3_data_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int b = 0; b < 4; b++)
        s1_prod_d[l][b] = dot_if.tmask_in[l] ?
          mul8(dot_if.is_signed_in, dot_if.rs1_data_in[l*XLEN+8*b +: 8], dot_if.rs2_data_in[l*XLEN+8*b +: 8]) : '0;
      s2_sum_d[l] = 19'($signed(s1_prod_q[l][0])) + 19'($signed(s1_prod_q[l][1]))
                  + 19'($signed(s1_prod_q[l][2])) + 19'($signed(s1_prod_q[l][3]));
      s3_data_d[l] = XLEN'($signed(s2_sum_q[l]));
    end
  end

  // payload only moves with a valid entry so idle outputs keep their last value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s1_prod_q  <= '0;
      s2_sum_q   <= '0;
      s3_data_q  <= '0;
      s1_mask_q  <= '0;
      s2_mask_q  <= '0;
      s3_mask_q  <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s3_tag_q   <= '0;
      op_count_q <= '0;
    end else begin
      if (s1_adv) s1_v_q <= dot_if.valid_in;
      if (s1_adv && dot_if.valid_in) begin
        s1_prod_q <= s1_prod_d;
        s1_mask_q <= dot_if.tmask_in;
        s1_tag_q  <= dot_if.tag_in;
      end
      if (s2_adv) s2_v_q <= s1_v_q;
      if (s2_adv && s1_v_q) begin
        s2_sum_q  <= s2_sum_d;
        s2_mask_q <= s1_mask_q;
        s2_tag_q  <= s1_tag_q;
      end
      if (s3_acc) s3_v_q <= s2_v_q;
      if (s3_acc && s2_v_q) begin
        s3_data_q <= s3_data_d;
        s3_mask_q <= s2_mask_q;
        s3_tag_q  <= s2_tag_q;
      end
      if (s3_v_q && dot_if.ready_out) op_count_q <= op_count_q + 32'd1;
    end
  end
endmodule
